// File: rtl/clock_pkg.sv
// Shared encodings for the 12-hour clock set controller: FSM states,
// counter field selects and BCD field limits.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SET_HH,
    ST_SET_MM,
    ST_SET_PM,
    ST_WR1,
    ST_WR2
  } state_e;

  localparam logic [1:0] SEL_SS = 2'd0;
  localparam logic [1:0] SEL_MM = 2'd1;
  localparam logic [1:0] SEL_HH = 2'd2;
  localparam logic [1:0] SEL_PM = 2'd3;

  localparam logic [7:0] HH_MIN = 8'h01;
  localparam logic [7:0] HH_MAX = 8'h12;
  localparam logic [7:0] MM_MIN = 8'h00;
  localparam logic [7:0] MM_MAX = 8'h59;

  // Display blink code for a (non-write) state.
  function automatic logic [1:0] mode_code(input state_e s);
    case (s)
      ST_SET_HH: mode_code = 2'd1;
      ST_SET_MM: mode_code = 2'd2;
      ST_SET_PM: mode_code = 2'd3;
      default:   mode_code = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_bcd_step.sv
// Combinational two-digit BCD step (i_dir=1 up, 0 down) with wrap between
// i_min and i_max; any out-of-range or non-BCD value clamps to i_min.
module bcd_step (
  input  logic [7:0] i_value,
  input  logic [7:0] i_min,
  input  logic [7:0] i_max,
  input  logic       i_dir,
  output logic [7:0] o_next
);

  logic [3:0] lo;
  logic [3:0] hi;
  logic       in_range;

  assign lo = i_value[3:0];
  assign hi = i_value[7:4];
  assign in_range = (lo <= 4'd9) && (hi <= 4'd9) &&
                    (i_value >= i_min) && (i_value <= i_max);

  always_comb begin
    o_next = i_min;
    if (in_range) begin
      if (i_dir) begin
        if (i_value == i_max)  o_next = i_min;
        else if (lo == 4'd9)   o_next = {hi + 4'd1, 4'd0};
        else                   o_next = {hi, lo + 4'd1};
      end else begin
        if (i_value == i_min)  o_next = i_max;
        else if (lo == 4'd0)   o_next = {hi - 4'd1, 4'd9};
        else                   o_next = {hi, lo - 4'd1};
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set sequencer for the 12-hour BCD clock counter: 1 Hz tick in RUN,
// button-driven field writes in set mode. Define DOWN_BTN_EN for i_btn_down.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000000,
  parameter int unsigned DIV_W   = 27
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
`ifdef DOWN_BTN_EN
  input  logic       i_btn_down,
`endif
  input  logic [7:0] i_hh,
  input  logic [7:0] i_mm,
  input  logic       i_pm,
  output logic       o_ena,
  output logic       o_wr,
  output logic [1:0] o_sel,
  output logic [7:0] o_in,
  output logic [1:0] o_mode,
  output logic       o_busy
);

  localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(CLK_DIV - 1);

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [1:0]       sel_q, sel_d;
  logic [7:0]       din_q, din_d;

  logic       btn_step;
  logic       step_dir;
  logic [7:0] step_val;
  logic [7:0] step_min;
  logic [7:0] step_max;
  logic [7:0] step_next;

`ifdef DOWN_BTN_EN
  assign btn_step = i_btn_up | i_btn_down;
  assign step_dir = i_btn_up;
`else
  assign btn_step = i_btn_up;
  assign step_dir = 1'b1;
`endif

  assign step_val = (state_q == ST_SET_HH) ? i_hh   : i_mm;
  assign step_min = (state_q == ST_SET_HH) ? HH_MIN : MM_MIN;
  assign step_max = (state_q == ST_SET_HH) ? HH_MAX : MM_MAX;

  bcd_step u_step (
    .i_value (step_val),
    .i_min   (step_min),
    .i_max   (step_max),
    .i_dir   (step_dir),
    .o_next  (step_next)
  );

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    pre_d   = pre_q;
    sel_d   = sel_q;
    din_d   = din_q;
    o_ena   = 1'b0;
    o_wr    = 1'b0;
    o_busy  = 1'b0;

    case (state_q)
      ST_RUN: begin
        o_ena = (pre_q == PRE_LAST);
        pre_d = o_ena ? '0 : pre_q + DIV_W'(1);
        if (i_btn_mode) begin
          state_d = ST_SET_HH;
          pre_d   = '0;
        end
      end

      ST_SET_HH, ST_SET_MM, ST_SET_PM: begin
        if (i_btn_mode) begin
          case (state_q)
            ST_SET_HH: state_d = ST_SET_MM;
            ST_SET_MM: state_d = ST_SET_PM;
            default: begin
              // Leaving set mode zeroes seconds so the minute starts cleanly.
              sel_d   = SEL_SS;
              din_d   = '0;
              ret_d   = ST_RUN;
              pre_d   = '0;
              state_d = ST_WR1;
            end
          endcase
        end else if (btn_step) begin
          ret_d   = state_q;
          state_d = ST_WR1;
          case (state_q)
            ST_SET_HH: begin sel_d = SEL_HH; din_d = step_next; end
            ST_SET_MM: begin sel_d = SEL_MM; din_d = step_next; end
            default:   begin sel_d = SEL_PM; din_d = {7'b0, ~i_pm}; end
          endcase
        end
      end

      ST_WR1: begin
        o_ena   = 1'b1;
        o_wr    = 1'b1;
        o_busy  = 1'b1;
        state_d = ST_WR2;
      end

      ST_WR2: begin
        o_ena   = 1'b1;
        o_wr    = 1'b1;
        o_busy  = 1'b1;
        state_d = ret_q;
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      pre_q   <= '0;
      sel_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      pre_q   <= pre_d;
      sel_q   <= sel_d;
      din_q   <= din_d;
    end
  end

  assign o_sel  = sel_q;
  assign o_in   = din_q;
  assign o_mode = ((state_q == ST_WR1) || (state_q == ST_WR2)) ? mode_code(ret_q)
                                                                 : mode_code(state_q);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl with CLK_DIV=4: expected enable events
// are queued at stimulus time and checked by an independent monitor.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_btn_mode;
  logic       i_btn_up;
  logic       i_btn_down;
  logic [7:0] i_hh;
  logic [7:0] i_mm;
  logic       i_pm;
  logic       o_ena;
  logic       o_wr;
  logic [1:0] o_sel;
  logic [7:0] o_in;
  logic [1:0] o_mode;
  logic       o_busy;

  always #5 clk = ~clk;

  clock_set_ctrl #(.CLK_DIV(4), .DIV_W(3)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_btn_mode (i_btn_mode),
    .i_btn_up   (i_btn_up),
`ifdef DOWN_BTN_EN
    .i_btn_down (i_btn_down),
`endif
    .i_hh       (i_hh),
    .i_mm       (i_mm),
    .i_pm       (i_pm),
    .o_ena      (o_ena),
    .o_wr       (o_wr),
    .o_sel      (o_sel),
    .o_in       (o_in),
    .o_mode     (o_mode),
    .o_busy     (o_busy)
  );

  typedef struct {
    int         cyc;
    bit         wr;
    bit         chk;
    logic [1:0] sel;
    logic [7:0] din;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;

  // Cycle 0 is the first cycle after the last reset edge (prescaler = 0).
  always @(posedge clk) cyc <= i_reset ? 0 : cyc + 1;

  task automatic push_tick(input int c);
    exp_t e;
    e.cyc = c; e.wr = 1'b0; e.chk = 1'b0; e.sel = 2'd0; e.din = 8'h00;
    sbq.push_back(e);
  endtask

  task automatic push_wr1(input int c, input logic [1:0] s, input logic [7:0] d);
    exp_t e;
    e.cyc = c; e.wr = 1'b1; e.chk = 1'b1; e.sel = s; e.din = d;
    sbq.push_back(e);
  endtask

  task automatic push_wr(input int c, input logic [1:0] s, input logic [7:0] d);
    push_wr1(c, s, d);
    push_wr1(c + 1, s, d);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    int n;
    n = 0;
    while (cyc != c && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cyc != c) begin
      total++;
      bad++;
      $display("FAIL wait_cyc: got cycle %0d expected %0d", cyc, c);
    end
  endtask

  task automatic press(input bit m, input bit u, input bit d);
    i_btn_mode = m;
    i_btn_up   = u;
    i_btn_down = d;
    @(negedge clk);
    i_btn_mode = 1'b0;
    i_btn_up   = 1'b0;
    i_btn_down = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (o_ena) begin
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ena: cyc=%0d wr=%0b sel=%0d in=%h, required no enable",
                   cyc, o_wr, o_sel, o_in);
        end else begin
          mon_e = sbq.pop_front();
          if (cyc != mon_e.cyc || o_wr !== mon_e.wr || o_busy !== mon_e.wr ||
              (mon_e.chk && (o_sel !== mon_e.sel || o_in !== mon_e.din))) begin
            bad++;
            $display("FAIL ena_event: got cyc=%0d wr=%0b busy=%0b sel=%0d in=%h, required cyc=%0d wr=%0b sel=%0d in=%h",
                     cyc, o_wr, o_busy, o_sel, o_in, mon_e.cyc, mon_e.wr, mon_e.sel, mon_e.din);
          end
        end
      end else if (o_wr !== 1'b0 || o_busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_strobe: cyc=%0d wr=%0b busy=%0b, required 0 0", cyc, o_wr, o_busy);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset = 1'b1; i_btn_mode = 1'b0; i_btn_up = 1'b0; i_btn_down = 1'b0;
    i_hh = 8'h01; i_mm = 8'h00; i_pm = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    chk("reset_outputs", {17'd0, o_ena, o_wr, o_sel, o_in, o_mode, o_busy}, 32'd0);
    i_reset = 1'b0;

    // Free-running ticks
    for (int k = 3; k <= 19; k += 4) push_tick(k);

    // Enter SET_HH, hours 12 -> 01, extra up during WR1 dropped
    wait_cyc(21); press(1'b1, 1'b0, 1'b0);
    wait_cyc(22); chk("mode_set_hh", {30'd0, o_mode}, 32'd1);
    i_hh = 8'h12;
    wait_cyc(30); push_wr(31, 2'd2, 8'h01); press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    wait_cyc(33); chk("mode_after_hh_wr", {30'd0, o_mode}, 32'd1);

    // SET_MM: 59 -> 00, 09 -> 10, invalid 5A -> 00
    wait_cyc(35); press(1'b1, 1'b0, 1'b0);
    wait_cyc(36); chk("mode_set_mm", {30'd0, o_mode}, 32'd2);
    i_mm = 8'h59;
    wait_cyc(37); push_wr(38, 2'd1, 8'h00); press(1'b0, 1'b1, 1'b0);
    i_mm = 8'h09;
    wait_cyc(41); push_wr(42, 2'd1, 8'h10); press(1'b0, 1'b1, 1'b0);
    i_mm = 8'h5A;
    wait_cyc(45); push_wr(46, 2'd1, 8'h00); press(1'b0, 1'b1, 1'b0);

    // SET_PM toggle, then exit with seconds clear and restarted prescaler
    wait_cyc(49); press(1'b1, 1'b0, 1'b0);
    wait_cyc(50); chk("mode_set_pm", {30'd0, o_mode}, 32'd3);
    i_pm = 1'b0;
    wait_cyc(51); push_wr(52, 2'd3, 8'h01); press(1'b0, 1'b1, 1'b0);
    wait_cyc(55); push_wr(56, 2'd0, 8'h00); push_tick(61); push_tick(65);
    press(1'b1, 1'b0, 1'b0);
    wait_cyc(58); chk("mode_run_again", {30'd0, o_mode}, 32'd0);

    // mode+up together: mode wins, no write
    wait_cyc(66); press(1'b1, 1'b1, 1'b0);
    wait_cyc(67); chk("mode_wins", {30'd0, o_mode}, 32'd1);
    i_hh = 8'h00;
    wait_cyc(69); push_wr(70, 2'd2, 8'h01); press(1'b0, 1'b1, 1'b0);
    i_hh = 8'h09;
    wait_cyc(73); push_wr(74, 2'd2, 8'h10); press(1'b0, 1'b1, 1'b0);

    // Reset during WR1 aborts the write
    i_hh = 8'h05;
    wait_cyc(77); push_wr1(78, 2'd2, 8'h06); press(1'b0, 1'b1, 1'b0);
    i_reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_write", {17'd0, o_ena, o_wr, o_sel, o_in, o_mode, o_busy}, 32'd0);
    i_reset = 1'b0;
    push_tick(3); push_tick(7);

`ifdef DOWN_BTN_EN
    wait_cyc(9); press(1'b1, 1'b0, 1'b0);
    i_hh = 8'h01;
    wait_cyc(11); push_wr(12, 2'd2, 8'h12); press(1'b0, 1'b0, 1'b1);
    i_hh = 8'h10;
    wait_cyc(15); push_wr(16, 2'd2, 8'h09); press(1'b0, 1'b0, 1'b1);
    wait_cyc(19); push_wr(20, 2'd2, 8'h11); press(1'b0, 1'b1, 1'b1);
`else
    for (int k = 11; k <= 23; k += 4) push_tick(k);
`endif

    wait_cyc(25);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
